// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch and load/store ports.
// One transaction outstanding; responses are routed back to the owner, with an optional timeout.
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                resp_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ready,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy,
   output logic [31:0]         conflict_cnt
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;
   typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   owner_e              win;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [31:0]         conflict_cnt_q, conflict_cnt_d;
   logic                tmo_hit, rsp_done, arb_en;

   assign tmo_hit  = (TIMEOUT != 0) && (state_q == WAIT) && !mem_rvalid
                     && (tmo_cnt_q == CNT_W'(TIMEOUT));
   assign rsp_done = (state_q == WAIT) && (mem_rvalid || tmo_hit);
   assign arb_en   = (state_q == IDLE) || rsp_done;

   // owner_q doubles as last_owner: it keeps the previous winner while idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         owner_q        <= OWN_D;
         addr_q         <= '0;
         we_q           <= 1'b0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
         tmo_cnt_q      <= '0;
         conflict_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         addr_q         <= addr_d;
         we_q           <= we_d;
         wdata_q        <= wdata_d;
         wstrb_q        <= wstrb_d;
         tmo_cnt_q      <= tmo_cnt_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      addr_d         = addr_q;
      we_d           = we_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      tmo_cnt_d      = tmo_cnt_q;
      conflict_cnt_d = conflict_cnt_q;
      win            = OWN_IF;
      case (state_q)
         ISSUE: begin
            if (mem_ready) begin
               state_d   = WAIT;
               tmo_cnt_d = '0;
            end
         end
         WAIT: begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            if (rsp_done) state_d = IDLE;
         end
         default: ;
      endcase
      if (arb_en && (if_req || d_req)) begin
         if (if_req && d_req) begin
            win            = (owner_q == OWN_D) ? OWN_IF : OWN_D;
            conflict_cnt_d = conflict_cnt_q + 32'd1;
         end else begin
            win = if_req ? OWN_IF : OWN_D;
         end
         owner_d = win;
         state_d = ISSUE;
         if (win == OWN_IF) begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            wstrb_d = '1;
         end else begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            wstrb_d = d_wstrb;
         end
      end
   end

   always_comb begin
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      d_gnt     = 1'b0;
      d_rvalid  = 1'b0;
      d_rdata   = '0;
      resp_err  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      case (state_q)
         ISSUE: begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_wstrb = wstrb_q;
            if (mem_ready) begin
               if (owner_q == OWN_IF) if_gnt = 1'b1;
               else                   d_gnt  = 1'b1;
            end
         end
         WAIT: begin
            if (rsp_done) begin
               resp_err = tmo_hit;
               if (owner_q == OWN_IF) begin
                  if_rvalid = 1'b1;
                  if_rdata  = mem_rvalid ? mem_rdata : '0;
               end else begin
                  d_rvalid = 1'b1;
                  d_rdata  = mem_rvalid ? mem_rdata : '0;
               end
            end
         end
         default: ;
      endcase
   end

   assign busy         = (state_q != IDLE);
   assign conflict_cnt = conflict_cnt_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the multicycle core's instruction-fetch port and its load/store port.
- Lets the core run against one memory instead of separate instruction and data memories.
- Arbitrates round-robin, keeps exactly one transaction outstanding, and routes each response back to its owner.
- Provides a response timeout and a contention counter for performance analysis.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT, 255, number of WAIT cycles before an error response is forced; 0 disables the timeout.

Ports:
- clk  input  1  clock; everything is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request.
- if_addr  input  ADDR_W  fetch address.
- if_gnt  output  1  fetch request accepted (one-cycle pulse).
- if_rvalid  output  1  fetch response valid.
- if_rdata  output  DATA_W  fetch response data.
- d_req  input  1  data request.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_wstrb  input  DATA_W/8  byte strobes.
- d_gnt  output  1  data request accepted (one-cycle pulse).
- d_rvalid  output  1  data response valid; also serves as the store completion.
- d_rdata  output  DATA_W  load data.
- resp_err  output  1  qualifies whichever rvalid is high; 1 = timed out.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_wstrb  output  DATA_W/8  memory byte strobes.
- mem_ready  input  1  memory accepts mem_req this cycle.
- mem_rvalid  input  1  memory response, one per accepted request, loads and stores alike.
- mem_rdata  input  DATA_W  memory read data.
- busy  output  1  state != IDLE.
- conflict_cnt  output  32  count of arbitrations with both requests high.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - All outputs, latched request fields and conflict_cnt = 0.
  - last_owner = DATA, so fetch wins the first tie.
  - Reset asserted mid-transaction abandons it; no rvalid is produced.
- Requester rule: a requester holds req and its fields stable until it sees gnt. Fields are sampled only at arbitration.
- Arbitration:
  - Occurs in IDLE, or in WAIT in the cycle mem_rvalid arrives, whenever any req is high.
  - Single requester: it wins.
  - Both requesters: the one that is not last_owner wins, and conflict_cnt increments (wraps at 2^32).
  - Winner's addr, we, wdata and wstrb are registered (fetch forces we = 0, wstrb = all 1s). owner and last_owner are updated. Next state = ISSUE.
- ISSUE:
  - mem_req = 1 with the registered fields.
  - When mem_ready = 1: owner's gnt = 1 combinationally in the same cycle, next state = WAIT, timeout counter cleared.
  - When mem_ready = 0: stay in ISSUE with fields held.
- WAIT:
  - mem_req = 0; the counter increments each cycle.
  - When mem_rvalid = 1: owner's rvalid = 1 and rdata = mem_rdata combinationally in the same cycle, resp_err = 0. Then re-arbitrate (next state ISSUE) or go to IDLE.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT without mem_rvalid: owner's rvalid = 1, rdata = 0, resp_err = 1. Then re-arbitrate or go to IDLE.
- Latency: req high in cycle N (IDLE) gives mem_req in N+1; with mem_ready high, gnt in N+1; earliest rvalid in N+2. Back-to-back transactions can issue every 2 cycles.
- Non-owner outputs: the non-owner's gnt and rvalid stay 0. Its rdata reads 0 whenever its rvalid is 0.
- Protocol violations from memory: mem_rvalid in IDLE or ISSUE (stray, or late after a timeout) is ignored and never forwarded.
- A req that drops before gnt is a protocol violation. The latched request still completes, and its gnt and rvalid are delivered.

Test Plan:
- Fetch only: if_req with addr 0x100; mem_ready = 1; mem_rvalid 1 cycle later with rdata 0x00500093 -> mem_req in cycle N+1, if_gnt in N+1, if_rvalid with 0x00500093 in N+2; d_gnt and d_rvalid stay 0.
- Tie after reset: if_req and d_req both high in the same cycle, repeated 3 times -> owners are IF, D, IF; conflict_cnt = 3.
- Store: d_we = 1, addr 0x2000, wdata 0xCAFEF00D, wstrb 4'b0011; mem_ready held low for 3 cycles -> mem_* fields stable for 4 cycles; d_gnt only in the accept cycle; d_rvalid when the memory acks.
- Timeout: TIMEOUT = 4, mem_rvalid never returned -> rvalid with resp_err = 1 and rdata = 0 after 4 WAIT cycles; a later stray mem_rvalid is ignored.
- Async reset: rst pulsed low during WAIT between clock edges -> busy = 0 immediately; no rvalid; the next tie is granted to fetch.
- Pipelined re-arbitration: d_req pending when the fetch's mem_rvalid arrives -> ISSUE on the next cycle with no IDLE cycle in between.
